// File: rtl/mac_sequencer.sv
// mac_sequencer: initiator side of the mac start/done handshake.
// Holds one input vector and N_NEURONS weight rows. On go it runs one mac pass per neuron.
// Each pass streams the operand pairs, waits for mac_done, applies optional ReLU and emits
// the result. All data is signed Q8.8.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for go; buffers writable
// S_START  | mac_start pulse, pair 0 of neuron n on the operand bus
// S_STREAM | remaining pairs 1..N_INPUTS-1 of neuron n
// S_WAIT   | operands zero, waiting for mac_done or timeout
// S_STORE  | result_valid pulse for neuron n
// S_DONE   | done pulse, then back to idle
module mac_sequencer #(
    parameter int N_INPUTS  = 8,
    parameter int N_NEURONS = 4,
    parameter int RELU      = 1,
    parameter int TIMEOUT   = 64,
    localparam int AW = ($clog2(N_INPUTS * N_NEURONS) < 1) ? 1 : $clog2(N_INPUTS * N_NEURONS),
    localparam int IW = ($clog2(N_NEURONS) < 1) ? 1 : $clog2(N_NEURONS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          go,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_data,
    output logic          mac_start,
    output logic [15:0]   mac_in,
    output logic [15:0]   weight,
    input  logic          mac_done,
    input  logic [15:0]   mac_out,
    output logic          result_valid,
    output logic [IW-1:0] result_idx,
    output logic [15:0]   result_data,
    output logic          busy,
    output logic          done,
    output logic          error
);

    // k must be able to hold N_INPUTS itself: it marks "last pair already driven"
    localparam int KW    = $clog2(N_INPUTS + 1);
    localparam int TW    = ($clog2(TIMEOUT) < 1) ? 1 : $clog2(TIMEOUT);
    localparam int DEPTH = 1 << AW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_STREAM,
        S_WAIT,
        S_STORE,
        S_DONE
    } state_t;

    state_t        state;
    logic [IW-1:0] n;
    logic [KW-1:0] k;
    logic [TW-1:0] tcnt;

    logic [15:0]   x_mem [DEPTH];
    logic [15:0]   w_mem [DEPTH];

    logic [AW-1:0] x_idx;
    logic [AW-1:0] w_idx;
    logic [AW-1:0] w_row;

    assign busy = (state != S_IDLE);

    // Buffer writes, accepted only while idle; out-of-range addresses are dropped
    always_ff @(posedge clk) begin
        if (wr_en && state == S_IDLE) begin
            if (!wr_sel && 32'(wr_addr) < N_INPUTS)
                x_mem[wr_addr] <= wr_data;
            if (wr_sel && 32'(wr_addr) < N_INPUTS * N_NEURONS)
                w_mem[wr_addr] <= wr_data;
        end
    end

    // Operand addresses: current pair k of row n, and pair 0 of the following row
    always_comb begin
        x_idx = AW'(k);
        w_idx = AW'(32'(n) * N_INPUTS + 32'(k));
        w_row = AW'((32'(n) + 32'd1) * N_INPUTS);
    end

    // Sequencer FSM; every output is registered and reflects the state being entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            n            <= '0;
            k            <= '0;
            tcnt         <= '0;
            mac_start    <= 1'b0;
            mac_in       <= '0;
            weight       <= '0;
            result_valid <= 1'b0;
            result_idx   <= '0;
            result_data  <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            mac_start    <= 1'b0;
            result_valid <= 1'b0;
            done         <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        error     <= 1'b0;
                        n         <= '0;
                        k         <= KW'(1);
                        mac_start <= 1'b1;
                        mac_in    <= x_mem['0];
                        weight    <= w_mem['0];
                        state     <= S_START;
                    end
                end
                S_START, S_STREAM: begin
                    if (k == KW'(N_INPUTS)) begin
                        mac_in <= '0;
                        weight <= '0;
                        tcnt   <= TW'(TIMEOUT - 1);
                        state  <= S_WAIT;
                    end else begin
                        mac_in <= x_mem[x_idx];
                        weight <= w_mem[w_idx];
                        k      <= k + KW'(1);
                        state  <= S_STREAM;
                    end
                end
                S_WAIT: begin
                    if (mac_done) begin
                        result_valid <= 1'b1;
                        result_idx   <= n;
                        result_data  <= (RELU != 0 && mac_out[15]) ? 16'h0000 : mac_out;
                        state        <= S_STORE;
                    end else if (tcnt == '0) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        tcnt <= tcnt - TW'(1);
                    end
                end
                S_STORE: begin
                    if (n == IW'(N_NEURONS - 1)) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        n         <= n + IW'(1);
                        k         <= KW'(1);
                        mac_start <= 1'b1;
                        mac_in    <= x_mem['0];
                        weight    <= w_mem[w_row];
                        state     <= S_START;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: directed bench for mac_sequencer with a behavioural Q8.8 mac model.
// A second instance with RELU=0 shares all stimulus so both activations are seen per pass.
module tb_mac_sequencer;

    localparam int NI = 8;
    localparam int NN = 4;
    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        go;
    logic        wr_en;
    logic        wr_sel;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        mac_done;
    logic [15:0] mac_out;

    logic        mac_start, result_valid, busy, done, error;
    logic [15:0] mac_in, weight, result_data;
    logic [1:0]  result_idx;

    logic        nr_mac_start, nr_result_valid, nr_busy, nr_done, nr_error;
    logic [15:0] nr_mac_in, nr_weight, nr_result_data;
    logic [1:0]  nr_result_idx;

    int n_checks = 0;
    int n_fail   = 0;

    logic        mac_mute = 1'b0;
    int          acc, prod, pair_cnt, dly;

    logic [15:0] res_data [8];
    logic [15:0] res_nr   [8];
    logic [1:0]  res_idx  [8];
    int          res_cnt;
    int          pass_cycles;
    logic        err_at_start;

    mac_sequencer #(.N_INPUTS(NI), .N_NEURONS(NN), .RELU(1), .TIMEOUT(TO)) u_dut (
        .clk(clk), .reset(reset), .go(go), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .mac_start(mac_start), .mac_in(mac_in),
        .weight(weight), .mac_done(mac_done), .mac_out(mac_out),
        .result_valid(result_valid), .result_idx(result_idx), .result_data(result_data),
        .busy(busy), .done(done), .error(error)
    );

    mac_sequencer #(.N_INPUTS(NI), .N_NEURONS(NN), .RELU(0), .TIMEOUT(TO)) u_dut_nr (
        .clk(clk), .reset(reset), .go(go), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .mac_start(nr_mac_start), .mac_in(nr_mac_in),
        .weight(nr_weight), .mac_done(mac_done), .mac_out(mac_out),
        .result_valid(nr_result_valid), .result_idx(nr_result_idx),
        .result_data(nr_result_data), .busy(nr_busy), .done(nr_done), .error(nr_error)
    );

    always #5 clk = ~clk;

    // mac model: Q8.8 multiply-accumulate, done two cycles after the last pair
    always @(negedge clk) begin
        if (reset) begin
            pair_cnt = 0;
            dly      = 0;
            mac_done = 1'b0;
        end else begin
            mac_done = 1'b0;
            if (dly > 0) begin
                dly = dly - 1;
                if (dly == 0 && !mac_mute) begin
                    mac_done = 1'b1;
                    mac_out  = acc[15:0];
                end
            end
            prod = ($signed(mac_in) * $signed(weight)) >>> 8;
            if (mac_start) begin
                acc      = prod;
                pair_cnt = 1;
            end else if (pair_cnt > 0) begin
                acc      = acc + prod;
                pair_cnt = pair_cnt + 1;
            end
            if (pair_cnt == NI) begin
                pair_cnt = 0;
                dly      = 2;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_buf(input logic sel, input logic [4:0] addr, input logic [15:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic load_uniform(input logic [15:0] xv, input logic [15:0] wv);
        for (int i = 0; i < NI; i++) write_buf(1'b0, 5'(i), xv);
        for (int a = 0; a < NI * NN; a++) write_buf(1'b1, 5'(a), wv);
    endtask

    task automatic run_pass();
        logic got_done;
        go = 1'b1;
        tick();
        go = 1'b0;
        err_at_start = error;
        res_cnt = 0;
        pass_cycles = 0;
        got_done = 1'b0;
        while (!got_done && pass_cycles < 1000) begin
            if (result_valid && res_cnt < 8) begin
                res_idx[res_cnt]  = result_idx;
                res_data[res_cnt] = result_data;
                res_nr[res_cnt]   = nr_result_data;
                res_cnt++;
            end
            if (done) got_done = 1'b1;
            else begin
                tick();
                pass_cycles++;
            end
        end
        check_val("pass_done_seen", 32'(got_done), 32'd1);
    endtask

    task automatic check_pass(input string tag, input logic [15:0] exp_d, input logic [15:0] exp_nr);
        check_val({tag, "_count"}, 32'(res_cnt), 32'(NN));
        check_val({tag, "_len"}, 32'(pass_cycles), 32'(NN * (NI + 2 + 1)));
        check_val({tag, "_error"}, 32'(error), 32'd0);
        for (int i = 0; i < res_cnt && i < NN; i++) begin
            check_val({tag, "_idx"}, 32'(res_idx[i]), 32'(i));
            check_val({tag, "_data"}, 32'(res_data[i]), 32'(exp_d));
            check_val({tag, "_data_norelu"}, 32'(res_nr[i]), 32'(exp_nr));
        end
    endtask

    task automatic wait_start();
        int c = 0;
        while (!mac_start && c < 100) begin tick(); c++; end
        check_val("start_seen", 32'(mac_start), 32'd1);
    endtask

    task automatic wait_done();
        int c = 0;
        while (!done && c < 200) begin tick(); c++; end
        check_val("done_seen", 32'(done), 32'd1);
    endtask

    initial begin
        int  w;
        logic seen_rv;
        reset = 1'b1; go = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        mac_done = 1'b0; mac_out = '0;
        tick(); tick();
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_start", 32'(mac_start), 32'd0);
        check_val("rst_rv", 32'(result_valid), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_error", 32'(error), 32'd0);
        check_val("rst_mac_in", 32'(mac_in), 32'd0);
        check_val("rst_weight", 32'(weight), 32'd0);
        check_val("rst_rdata", 32'(result_data), 32'd0);
        reset = 1'b0;
        tick();

        // 1.0 * 1.0 summed over 8 pairs -> 8.0
        load_uniform(16'h0100, 16'h0100);
        run_pass();
        check_pass("unity", 16'h0800, 16'h0800);
        tick();
        check_val("idle_busy", 32'(busy), 32'd0);

        // negative sum: clamped with ReLU, passed through without
        load_uniform(16'hFFFF, 16'h0200);
        run_pass();
        check_pass("negative", 16'h0000, 16'hFFF0);
        tick();

        // operand stream order, with go and writes attempted mid-pass
        for (int i = 0; i < NI; i++) write_buf(1'b0, 5'(i), 16'(16'h0010 + i));
        for (int a = 0; a < NI * NN; a++) write_buf(1'b1, 5'(a), 16'(16'h0200 + a));
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int nn = 0; nn < NN; nn++) begin
            wait_start();
            for (int kk = 0; kk < NI; kk++) begin
                check_val("stream_x", 32'(mac_in), 32'(16'h0010 + kk));
                check_val("stream_w", 32'(weight), 32'(16'h0200 + nn * NI + kk));
                check_val("stream_start", 32'(mac_start), 32'(kk == 0));
                if (nn == 1 && kk == 3) begin
                    go = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 5'd2; wr_data = 16'h7777;
                end
                if (nn == 2 && kk == 5) begin
                    wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 5'd24; wr_data = 16'h7777;
                end
                tick();
                go = 1'b0;
                wr_en = 1'b0;
            end
            check_val("wait_x", 32'(mac_in), 32'd0);
            check_val("wait_w", 32'(weight), 32'd0);
            check_val("wait_busy", 32'(busy), 32'd1);
        end
        wait_done();
        check_val("stream_error", 32'(error), 32'd0);
        tick();

        // next pass sees buffers untouched by the mid-pass writes
        go = 1'b1;
        tick();
        go = 1'b0;
        check_val("keep_x0", 32'(mac_in), 32'h0010);
        tick(); tick();
        check_val("keep_x2", 32'(mac_in), 32'h0012);
        wait_done();
        tick();

        // mac never answers: WAIT lasts TIMEOUT cycles, then error and done
        load_uniform(16'h0100, 16'h0100);
        mac_mute = 1'b1;
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int i = 0; i < NI; i++) tick();
        w = 0;
        seen_rv = 1'b0;
        while (!done && w < 200) begin
            if (result_valid) seen_rv = 1'b1;
            tick();
            w++;
        end
        check_val("timeout_len", 32'(w), 32'(TO));
        check_val("timeout_done", 32'(done), 32'd1);
        check_val("timeout_error", 32'(error), 32'd1);
        check_val("timeout_no_result", 32'(seen_rv), 32'd0);
        tick();
        check_val("timeout_idle", 32'(busy), 32'd0);
        check_val("timeout_sticky", 32'(error), 32'd1);
        mac_mute = 1'b0;
        tick(); tick(); tick();
        run_pass();
        check_val("go_clears_error", 32'(err_at_start), 32'd0);
        check_pass("after_timeout", 16'h0800, 16'h0800);
        tick();

        // reset in STREAM aborts at once, then a clean pass follows
        go = 1'b1;
        tick();
        go = 1'b0;
        tick(); tick(); tick();
        check_val("pre_reset_x", 32'(mac_in), 32'h0100);
        reset = 1'b1;
        #1;
        check_val("areset_busy", 32'(busy), 32'd0);
        check_val("areset_mac_in", 32'(mac_in), 32'd0);
        check_val("areset_weight", 32'(weight), 32'd0);
        tick();
        check_val("areset_done", 32'(done), 32'd0);
        check_val("areset_rv", 32'(result_valid), 32'd0);
        reset = 1'b0;
        tick(); tick();
        run_pass();
        check_pass("post_reset", 16'h0800, 16'h0800);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
